// File: rtl/cu_pkg.sv
// Shared definitions for the control_unit microsequencer: state encoding,
// opcode and branch-condition codes, the registered strobe bundle, and
// small decode helpers used by both the sequencer and the output decoder.
package cu_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_FETCH1,
    ST_FETCH2,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_MEMADDR,
    ST_MEM,
    ST_BR,
    ST_STK,
    ST_HALT,
    ST_ERR,
    ST_PAUSE
  } state_e;

  localparam logic [3:0] OP_ALU_RR = 4'b0000;
  localparam logic [3:0] OP_ALU_RI = 4'b0001;
  localparam logic [3:0] OP_LOAD   = 4'b0010;
  localparam logic [3:0] OP_STORE  = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_STACK  = 4'b0101;
  localparam logic [3:0] OP_HALT   = 4'b1111;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_ZERO   = 2'b01;
  localparam logic [1:0] BR_NZERO  = 2'b10;
  localparam logic [1:0] BR_NEVER  = 2'b11;

  // *_rdy fields are armed for the whole wait state and only reach the
  // datapath in the cycle mem_ready is high.
  typedef struct packed {
    logic       ld_mar;
    logic       ld_ir_rdy;
    logic       ld_pc;
    logic       ld_sp;
    logic       ld_sp_rdy;
    logic       ld_reg;
    logic       ld_alureg;
    logic       t_pc;
    logic       t_sp;
    logic       t_reg;
    logic       t_label;
    logic       alu_on;
    logic       mm;
    logic [2:0] fn_select;
    logic       inc_pc_rdy;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       bus_err;
  } strobes_t;

  // Branch condition evaluation on the ALU zero flag.
  function automatic logic br_taken(input logic [1:0] cond, input logic zero);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_ALWAYS: taken = 1'b1;
      BR_ZERO:   taken = zero;
      BR_NZERO:  taken = !zero;
      BR_NEVER:  taken = 1'b0;
    endcase
    return taken;
  endfunction

  // STORE and PUSH write memory; LOAD and POP read it.
  function automatic logic mem_is_write(input logic [3:0] op, input logic [1:0] sub);
    return (op == OP_STORE) || ((op == OP_STACK) && !sub[0]);
  endfunction

endpackage

// File: rtl/cu_outdec.sv
// Pure combinational decode from a sequencer state plus IR fields to the
// datapath strobe bundle. Fed with the next state so the registered copy is
// valid in the cycle the state is entered.
// Ports: state (state being entered), ir_1/ir_2/funct (IR fields),
//        zero (ALU flag), strobes_c (decoded strobes, combinational).
module cu_outdec
  import cu_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] ir_1,
  input  logic [1:0] ir_2,
  input  logic [2:0] funct,
  input  logic       zero,
  output strobes_t   strobes_c
);

  always_comb begin
    strobes_c = '0;
    case (state)
      ST_INIT:    strobes_c.ld_sp = 1'b1;
      ST_FETCH1: begin
        strobes_c.t_pc   = 1'b1;
        strobes_c.ld_mar = 1'b1;
      end
      ST_FETCH2: begin
        strobes_c.mem_rd     = 1'b1;
        strobes_c.ld_ir_rdy  = 1'b1;
        strobes_c.inc_pc_rdy = 1'b1;
      end
      ST_EXEC: begin
        strobes_c.alu_on    = 1'b1;
        strobes_c.fn_select = funct;
        strobes_c.ld_alureg = 1'b1;
        strobes_c.mm        = (ir_1 == OP_ALU_RI);
      end
      ST_WB:      strobes_c.ld_reg = 1'b1;
      ST_MEMADDR: begin
        strobes_c.t_reg  = 1'b1;
        strobes_c.ld_mar = 1'b1;
      end
      ST_MEM: begin
        if (mem_is_write(ir_1, ir_2)) begin
          strobes_c.mem_wr = 1'b1;
          strobes_c.t_reg  = 1'b1;
        end else begin
          strobes_c.mem_rd = 1'b1;
        end
        strobes_c.ld_sp_rdy = (ir_1 == OP_STACK);
      end
      ST_BR: begin
        if (br_taken(ir_2, zero)) begin
          strobes_c.t_label = 1'b1;
          strobes_c.ld_pc   = 1'b1;
        end
      end
      ST_STK: begin
        strobes_c.t_sp   = 1'b1;
        strobes_c.ld_mar = 1'b1;
      end
      ST_HALT:    strobes_c.halted  = 1'b1;
      ST_ERR:     strobes_c.bus_err = 1'b1;
      default:    strobes_c = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle microsequencer driving the datapath control strobes.
// Optional build macro SINGLE_STEP_EN adds a step input and a PAUSE state
// that every return to FETCH1 passes through.
// Ports: clk, rst_n (async active-low); ir_1/ir_2/funct IR fields; zero flag;
//        mem_ready handshake; register loads, tristate enables, ALU controls,
//        mem_rd/mem_wr requests, sticky halted/bus_err.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX  = 15,
  parameter int unsigned RESET_SP_LOAD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] ir_1,
  input  logic [1:0] ir_2,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ldMAR,
  output logic       ldIR,
  output logic       ldPC,
  output logic       ldSP,
  output logic       ldReg,
  output logic       ldALUreg,
  output logic       Tpc,
  output logic       Tsp,
  output logic       Treg,
  output logic       Tlabel,
  output logic       ALUon,
  output logic       mm,
  output logic [2:0] fnSelect,
  output logic       incPC,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       bus_err
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);
`ifdef SINGLE_STEP_EN
  localparam state_e FETCH_ENTRY = ST_PAUSE;
`else
  localparam state_e FETCH_ENTRY = ST_FETCH1;
`endif

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              boot_q;
  strobes_t          strobes_d, strobes_q;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (boot_q) begin
      // First edge after reset enters INIT (stack-pointer load) or FETCH1.
      state_d = (RESET_SP_LOAD != 0) ? ST_INIT : FETCH_ENTRY;
    end else begin
      case (state_q)
        ST_INIT:    state_d = FETCH_ENTRY;
        ST_FETCH1:  state_d = ST_FETCH2;
        ST_FETCH2:  if (mem_ready) state_d = ST_DECODE;
        ST_DECODE: begin
          case (ir_1)
            OP_ALU_RR, OP_ALU_RI: state_d = ST_EXEC;
            OP_LOAD, OP_STORE:    state_d = ST_MEMADDR;
            OP_BRANCH:            state_d = ST_BR;
            OP_STACK:             state_d = ST_STK;
            OP_HALT:              state_d = ST_HALT;
            default:              state_d = ST_ERR;
          endcase
        end
        ST_EXEC:    state_d = ST_WB;
        ST_WB:      state_d = FETCH_ENTRY;
        ST_MEMADDR: state_d = ST_MEM;
        ST_MEM: begin
          if (mem_ready) state_d = mem_is_write(ir_1, ir_2) ? FETCH_ENTRY : ST_WB;
        end
        ST_BR:      state_d = FETCH_ENTRY;
        ST_STK:     state_d = ST_MEM;
        ST_HALT, ST_ERR: state_d = state_q;
`ifdef SINGLE_STEP_EN
        ST_PAUSE:   if (step) state_d = ST_FETCH1;
`endif
        default:    state_d = ST_ERR;
      endcase

      // Memory wait timeout shared by instruction fetch and data access.
      if ((state_q == ST_FETCH2 || state_q == ST_MEM) && !mem_ready) begin
        if (wait_cnt_q == WAIT_LAST) state_d = ST_ERR;
        else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  cu_outdec u_outdec (
    .state     (state_d),
    .ir_1      (ir_1),
    .ir_2      (ir_2),
    .funct     (funct),
    .zero      (zero),
    .strobes_c (strobes_d)
  );

  // State, counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH1;
      wait_cnt_q <= '0;
      boot_q     <= 1'b1;
      strobes_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      boot_q     <= 1'b0;
      strobes_q  <= strobes_d;
    end
  end

  // Completion strobes are armed by the wait state and qualified by mem_ready.
  assign ldMAR    = strobes_q.ld_mar;
  assign ldIR     = strobes_q.ld_ir_rdy & mem_ready;
  assign ldPC     = strobes_q.ld_pc;
  assign ldSP     = strobes_q.ld_sp | (strobes_q.ld_sp_rdy & mem_ready);
  assign ldReg    = strobes_q.ld_reg;
  assign ldALUreg = strobes_q.ld_alureg;
  assign Tpc      = strobes_q.t_pc;
  assign Tsp      = strobes_q.t_sp;
  assign Treg     = strobes_q.t_reg;
  assign Tlabel   = strobes_q.t_label;
  assign ALUon    = strobes_q.alu_on;
  assign mm       = strobes_q.mm;
  assign fnSelect = strobes_q.fn_select;
  assign incPC    = strobes_q.inc_pc_rdy & mem_ready;
  assign mem_rd   = strobes_q.mem_rd;
  assign mem_wr   = strobes_q.mem_wr;
  assign halted   = strobes_q.halted;
  assign bus_err  = strobes_q.bus_err;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level trace model
// produces per-cycle stimulus and expected strobes; one loop applies and
// compares them every cycle, including the tristate exclusivity rule.
module tb_control_unit;

  typedef struct packed {
    logic       ld_mar, ld_ir, ld_pc, ld_sp, ld_reg, ld_alureg;
    logic       t_pc, t_sp, t_reg, t_label;
    logic       alu_on, mm;
    logic [2:0] fn;
    logic       inc_pc, mem_rd, mem_wr, halted, bus_err;
  } ov_t;

  typedef struct packed {
    logic [3:0] ir1;
    logic [1:0] ir2;
    logic [2:0] fn;
    logic       z;
    logic       rdy;
  } st_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] ir_1 = '0;
  logic [1:0] ir_2 = '0;
  logic [2:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       ldMAR, ldIR, ldPC, ldSP, ldReg, ldALUreg;
  logic       Tpc, Tsp, Treg, Tlabel, ALUon, mm, incPC;
  logic [2:0] fnSelect;
  logic       mem_rd, mem_wr, halted, bus_err;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .ir_1(ir_1), .ir_2(ir_2), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .ldMAR(ldMAR), .ldIR(ldIR), .ldPC(ldPC), .ldSP(ldSP), .ldReg(ldReg),
    .ldALUreg(ldALUreg), .Tpc(Tpc), .Tsp(Tsp), .Treg(Treg), .Tlabel(Tlabel),
    .ALUon(ALUon), .mm(mm), .fnSelect(fnSelect), .incPC(incPC),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .bus_err(bus_err)
  );

  int  checks = 0;
  int  failures = 0;
  st_t sq[$];
  ov_t eq[$];
  logic [3:0] c_ir1;
  logic [1:0] c_ir2;
  logic [2:0] c_fn;
  logic       c_z;

  function automatic ov_t dut_out();
    ov_t o;
    o.ld_mar = ldMAR; o.ld_ir = ldIR; o.ld_pc = ldPC; o.ld_sp = ldSP;
    o.ld_reg = ldReg; o.ld_alureg = ldALUreg; o.t_pc = Tpc; o.t_sp = Tsp;
    o.t_reg = Treg; o.t_label = Tlabel; o.alu_on = ALUon; o.mm = mm;
    o.fn = fnSelect; o.inc_pc = incPC; o.mem_rd = mem_rd; o.mem_wr = mem_wr;
    o.halted = halted; o.bus_err = bus_err;
    return o;
  endfunction

  task automatic check_ov(input string name, input ov_t got, input ov_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---- trace model: one entry per clock cycle ----
  task automatic emit(input logic rdy, input ov_t o);
    st_t s;
    s.ir1 = c_ir1; s.ir2 = c_ir2; s.fn = c_fn; s.z = c_z; s.rdy = rdy;
    sq.push_back(s);
    eq.push_back(o);
  endtask

  task automatic term(input logic err, input int n);
    ov_t o;
    o = '0;
    if (err) o.bus_err = 1'b1; else o.halted = 1'b1;
    repeat (n) emit(1'b1, o);
  endtask

  task automatic boot_entry();
    ov_t o;
    c_ir1 = '0; c_ir2 = '0; c_fn = '0; c_z = 1'b0;
    o = '0; o.ld_sp = 1'b1;
    emit(1'b1, o);
  endtask

  task automatic wb();
    ov_t o;
    o = '0; o.ld_reg = 1'b1;
    emit(1'b1, o);
  endtask

  // Memory data phase; gives up after 15 unanswered cycles.
  task automatic mem_phase(input logic wr, input logic sp, input int mlat, output logic dead);
    ov_t o;
    o = '0;
    if (wr) begin o.mem_wr = 1'b1; o.t_reg = 1'b1; end
    else o.mem_rd = 1'b1;
    dead = 1'b0;
    if (mlat >= 15) begin
      repeat (15) emit(1'b0, o);
      term(1'b1, 4);
      dead = 1'b1;
    end else begin
      repeat (mlat) emit(1'b0, o);
      if (sp) o.ld_sp = 1'b1;
      emit(1'b1, o);
    end
  endtask

  task automatic instr(input logic [3:0] op, input logic [1:0] sub, input logic [2:0] fn,
                       input logic z, input int flat, input int mlat);
    ov_t  o;
    logic dead;
    logic taken;
    c_ir1 = op; c_ir2 = sub; c_fn = fn; c_z = z;
    o = '0; o.t_pc = 1'b1; o.ld_mar = 1'b1;
    emit(1'b1, o);
    o = '0; o.mem_rd = 1'b1;
    if (flat >= 15) begin
      repeat (15) emit(1'b0, o);
      term(1'b1, 4);
      return;
    end
    repeat (flat) emit(1'b0, o);
    o.ld_ir = 1'b1; o.inc_pc = 1'b1;
    emit(1'b1, o);
    o = '0;
    emit(1'b1, o);
    case (op)
      4'h0, 4'h1: begin
        o = '0; o.alu_on = 1'b1; o.fn = fn; o.ld_alureg = 1'b1; o.mm = (op == 4'h1);
        emit(1'b1, o);
        wb();
      end
      4'h2, 4'h3: begin
        o = '0; o.t_reg = 1'b1; o.ld_mar = 1'b1;
        emit(1'b1, o);
        mem_phase(op == 4'h3, 1'b0, mlat, dead);
        if (!dead && op == 4'h2) wb();
      end
      4'h4: begin
        taken = (sub == 2'd0) || (sub == 2'd1 && z) || (sub == 2'd2 && !z);
        o = '0;
        if (taken) begin o.t_label = 1'b1; o.ld_pc = 1'b1; end
        emit(1'b1, o);
      end
      4'h5: begin
        o = '0; o.t_sp = 1'b1; o.ld_mar = 1'b1;
        emit(1'b1, o);
        mem_phase(!sub[0], 1'b1, mlat, dead);
        if (!dead && sub[0]) wb();
      end
      4'hF:    term(1'b0, 4);
      default: term(1'b1, 4);
    endcase
  endtask

  task automatic clear_model();
    sq.delete();
    eq.delete();
  endtask

  // Apply each cycle's inputs just after the edge, compare at the falling edge.
  task automatic run_prog(input string name);
    ov_t got;
    for (int i = 0; i < eq.size(); i++) begin
      @(posedge clk);
      #1;
      ir_1 = sq[i].ir1; ir_2 = sq[i].ir2; funct = sq[i].fn;
      zero = sq[i].z; mem_ready = sq[i].rdy;
      @(negedge clk);
      got = dut_out();
      check_ov($sformatf("%s[%0d]", name, i), got, eq[i]);
      checks++;
      if (!$onehot0({Tpc, Tsp, Treg, Tlabel})) begin
        failures++;
        $display("FAIL tristate %s[%0d] got=%b expected=one-hot-or-zero", name, i,
                 {Tpc, Tsp, Treg, Tlabel});
      end
    end
    clear_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1; ir_1 = '0; ir_2 = '0; funct = '0; zero = 1'b0;
    repeat (2) @(negedge clk);
    check_ov("reset_outputs", dut_out(), '0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ov_t lit;
    int  n_rd;
    logic dead;

    // Pin the model against hand-derived traces.
    instr(4'h0, 2'd0, 3'b100, 1'b0, 0, 0);
    check_int("model_alu_rr_len", eq.size(), 5);
    lit = '0; lit.alu_on = 1'b1; lit.fn = 3'b100; lit.ld_alureg = 1'b1;
    check_ov("model_alu_rr_exec", eq[3], lit);
    clear_model();
    instr(4'h2, 2'd0, 3'b000, 1'b0, 0, 3);
    n_rd = 0;
    foreach (eq[i]) if (eq[i].mem_rd) n_rd++;
    check_int("model_load_len", eq.size(), 9);
    check_int("model_load_rd_cycles", n_rd, 5);
    clear_model();

    // Program A: the full instruction mix ending in HALT.
    do_reset();
    boot_entry();
    instr(4'h0, 2'd0, 3'b100, 1'b0, 0, 0);
    instr(4'h1, 2'd0, 3'b011, 1'b0, 0, 0);
    instr(4'h2, 2'd0, 3'b000, 1'b0, 0, 3);
    instr(4'h3, 2'd0, 3'b000, 1'b0, 0, 1);
    instr(4'h4, 2'd1, 3'b000, 1'b1, 0, 0);
    instr(4'h4, 2'd1, 3'b000, 1'b0, 0, 0);
    instr(4'h4, 2'd2, 3'b000, 1'b0, 0, 0);
    instr(4'h4, 2'd0, 3'b000, 1'b0, 0, 0);
    instr(4'h4, 2'd3, 3'b000, 1'b1, 0, 0);
    instr(4'h5, 2'd0, 3'b000, 1'b0, 0, 2);
    instr(4'h5, 2'd1, 3'b000, 1'b0, 0, 0);
    instr(4'h0, 2'd0, 3'b111, 1'b0, 2, 0);
    instr(4'hF, 2'd0, 3'b000, 1'b0, 0, 0);
    run_prog("progA");

    // Program B: illegal opcode.
    do_reset();
    boot_entry();
    instr(4'h0, 2'd0, 3'b001, 1'b0, 0, 0);
    instr(4'h6, 2'd0, 3'b000, 1'b0, 0, 0);
    run_prog("illegal");

    // Program C: instruction fetch timeout.
    do_reset();
    boot_entry();
    instr(4'h0, 2'd0, 3'b000, 1'b0, 15, 0);
    run_prog("fetch_timeout");

    // Program D: data read timeout.
    do_reset();
    boot_entry();
    instr(4'h2, 2'd0, 3'b000, 1'b0, 0, 15);
    run_prog("load_timeout");

    // Program E: reset in the middle of a fetch wait, then a clean restart.
    do_reset();
    boot_entry();
    c_ir1 = 4'h0;
    lit = '0; lit.t_pc = 1'b1; lit.ld_mar = 1'b1;
    emit(1'b1, lit);
    lit = '0; lit.mem_rd = 1'b1;
    repeat (3) emit(1'b0, lit);
    run_prog("midwait");
    rst_n = 1'b0;
    #1;
    check_int("midwait_rst_mem_rd", int'(mem_rd), 0);
    check_ov("midwait_rst_outputs", dut_out(), '0);
    do_reset();
    boot_entry();
    instr(4'h0, 2'd0, 3'b100, 1'b0, 0, 0);
    instr(4'h5, 2'd0, 3'b000, 1'b0, 1, 15);
    run_prog("restart");
    dead = halted;
    check_int("restart_not_halted", int'(dead), 0);
    check_int("restart_bus_err", int'(bus_err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
